// File: rtl/edge_det_pkg.sv
// Shared types for the edge detector bank: per-channel edge qualification mode.
package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

endpackage

// File: rtl/edge_det_chan.sv
// One channel: synchroniser, optional debounce (EDGE_DET_BANK_DEBOUNCE_EN), edge qualify,
// registered pulse, sticky flag and saturating event counter.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 sig_in,
  input  logic [1:0]           mode,
  input  logic                 clear,
  output logic                 edge_seen,
  output logic                 level,
  output logic                 sticky,
  output logic [CNT_WIDTH-1:0] count
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_out;
  logic                   prev_q, prev_d;
  logic                   edge_q, edge_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   qual;
  edge_mode_t             mode_e;

  // A debounce window below one cycle has no meaning; nothing is built for it.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
  end

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    s_out  = sync_q[SYNC_STAGES-1];
  end

`ifdef EDGE_DET_BANK_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DBW-1:0] db_q, db_d;
  logic           lvl_q, lvl_d;

  // Any cycle of agreement restarts the window, so only a sustained mismatch moves level.
  always_comb begin
    lvl_d = lvl_q;
    db_d  = '0;
    if (s_out != lvl_q) begin
      if (db_q == DBW'(DEBOUNCE_CYCLES - 1)) lvl_d = s_out;
      else                                   db_d  = db_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_q  <= '0;
      lvl_q <= 1'b0;
    end else begin
      db_q  <= db_d;
      lvl_q <= lvl_d;
    end
  end

  assign level = lvl_q;
`else
  assign level = s_out;
`endif

  always_comb begin
    mode_e = edge_mode_t'(mode);
    unique case (mode_e)
      EDGE_RISE: qual = level & ~prev_q;
      EDGE_FALL: qual = ~level & prev_q;
      EDGE_BOTH: qual = level ^ prev_q;
      default:   qual = 1'b0;
    endcase
  end

  // A clear coinciding with an edge keeps that edge: sticky stays set, count restarts at 1.
  always_comb begin
    prev_d   = level;
    edge_d   = qual;
    sticky_d = qual | (sticky_q & ~clear);
    cnt_d    = cnt_q;
    if (clear)                 cnt_d = CNT_WIDTH'(qual);
    else if (qual && ~&cnt_q)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      edge_q   <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      edge_q   <= edge_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign edge_seen = edge_q;
  assign sticky    = sticky_q;
  assign count     = cnt_q;

endmodule

// File: rtl/edge_det_bank.sv
// Bank of independent edge-detect channels; the top only slices the packed vectors.
// Debounce is built in when EDGE_DET_BANK_DEBOUNCE_EN is defined.
module edge_det_bank
  import edge_det_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           signal,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CHANNELS-1:0]           clear,
  output logic [CHANNELS-1:0]           edge_seen,
  output logic [CHANNELS-1:0]           level,
  output logic [CHANNELS-1:0]           sticky,
  output logic [CHANNELS*CNT_WIDTH-1:0] count
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_chan (
      .clock     (clock),
      .reset_n   (reset_n),
      .sig_in    (signal[i]),
      .mode      (mode[2*i +: 2]),
      .clear     (clear[i]),
      .edge_seen (edge_seen[i]),
      .level     (level[i]),
      .sticky    (sticky[i]),
      .count     (count[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_edge_det_bank.sv
// Directed bench for edge_det_bank: table of steady-state vectors plus timed sequences.
module tb_edge_det_bank;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DB = 8;
  localparam int CW = 4;
`ifdef EDGE_DET_BANK_DEBOUNCE_EN
  localparam int LAT    = SS + DB + 1;
  localparam int HI_LEN = 12;
`else
  localparam int LAT    = SS + 1;
  localparam int HI_LEN = 5;
`endif
  localparam int HOLD = LAT + 3;

  logic              clock;
  logic              reset_n;
  logic [CH-1:0]     signal;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     clear;
  logic [CH-1:0]     edge_seen;
  logic [CH-1:0]     level;
  logic [CH-1:0]     sticky;
  logic [CH*CW-1:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  edge_det_bank #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .CNT_WIDTH       (CW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .signal    (signal),
    .mode      (mode),
    .clear     (clear),
    .edge_seen (edge_seen),
    .level     (level),
    .sticky    (sticky),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [CH-1:0]    sig;
    logic [2*CH-1:0]  md;
    logic [CH-1:0]    clr;
    logic [CH-1:0]    lvl;
    logic [CH-1:0]    stk;
    logic [CH*CW-1:0] cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pulse(input int ch, input int budget, output int cyc);
    cyc = -1;
    for (int k = 1; k <= budget && cyc < 0; k++) begin
      tick();
      if (edge_seen[ch]) cyc = k;
    end
  endtask

  // Drive ch0 high for len sampled edges, then low; log pulses over the window.
  task automatic run_pulse(input int len, input int window,
                           output int npulse, output int first, output int second);
    npulse = 0; first = -1; second = -1;
    signal[0] = 1'b1;
    for (int k = 1; k <= window; k++) begin
      tick();
      if (edge_seen[0]) begin
        npulse++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      if (k == len) signal[0] = 1'b0;
    end
  endtask

  initial begin
    int c, np, f, s;

    tbl[0]  = '{4'b0000, 8'h00, 4'b1111, 4'b0000, 4'b0000, 16'h0000};
    tbl[1]  = '{4'b0010, 8'h00, 4'b0000, 4'b0010, 4'b0000, 16'h0000};
    tbl[2]  = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 16'h0000};
    tbl[3]  = '{4'b0010, 8'h00, 4'b0000, 4'b0010, 4'b0000, 16'h0000};
    tbl[4]  = '{4'b0000, 8'h04, 4'b0000, 4'b0000, 4'b0000, 16'h0000};
    tbl[5]  = '{4'b0010, 8'h04, 4'b0000, 4'b0010, 4'b0010, 16'h0010};
    tbl[6]  = '{4'b0000, 8'h04, 4'b0000, 4'b0000, 4'b0010, 16'h0010};
    tbl[7]  = '{4'b0010, 8'h08, 4'b0000, 4'b0010, 4'b0010, 16'h0010};
    tbl[8]  = '{4'b0000, 8'h08, 4'b0000, 4'b0000, 4'b0010, 16'h0020};
    tbl[9]  = '{4'b1111, 8'hFF, 4'b0000, 4'b1111, 4'b1111, 16'h1131};
    tbl[10] = '{4'b0101, 8'hFF, 4'b0000, 4'b0101, 4'b1111, 16'h2141};
    tbl[11] = '{4'b0101, 8'hFF, 4'b1111, 4'b0101, 4'b0000, 16'h0000};

    reset_n = 1'b0; signal = '0; mode = '0; clear = '0;
    tick(); tick();
    chk("reset edge_seen", edge_seen, 0);
    chk("reset level", level, 0);
    chk("reset sticky", sticky, 0);
    chk("reset count", count, 0);
    reset_n = 1'b1;

    // Single rise on ch0, exact latency
    mode = 8'h55;
    signal = 4'b0001;
    wait_pulse(0, 40, c);
    chk("t1 pulse latency", c, LAT);
    tick();
    chk("t1 pulse one cycle", edge_seen, 0);
    chk("t1 level", level, 4'b0001);
    chk("t1 sticky", sticky, 4'b0001);
    chk("t1 count", count, 16'h0001);

    // Both edges, then fall only
    mode = 8'h00; signal = '0;
    repeat (HOLD) tick();
    clear = 4'hF; tick(); clear = '0;
    mode = 8'h03;
    run_pulse(HI_LEN, HI_LEN + LAT + 4, np, f, s);
    chk("t2 both npulse", np, 2);
    chk("t2 both first", f, LAT);
    chk("t2 both spacing", s - f, HI_LEN);
    chk("t2 both count", count[3:0], 2);
    clear = 4'h1; tick(); clear = '0;
    mode = 8'h02;
    run_pulse(HI_LEN, HI_LEN + LAT + 4, np, f, s);
    chk("t2 fall npulse", np, 1);
    chk("t2 fall position", f, HI_LEN + LAT);
    chk("t2 fall count", count[3:0], 1);

`ifdef EDGE_DET_BANK_DEBOUNCE_EN
    mode = 8'h03;
    run_pulse(5, 30, np, f, s);
    chk("t3 glitch npulse", np, 0);
    chk("t3 glitch level", level[0], 0);
    chk("t3 glitch count", count[3:0], 1);
`endif
    mode = 8'h01;
    run_pulse(20, 20 + LAT + 4, np, f, s);
    chk("t3 long npulse", np, 1);
    chk("t3 long latency", f, LAT);
    chk("t3 long count", count[3:0], 2);

    // Saturation, then clear coinciding with a qualified edge
    clear = 4'h1; tick(); clear = '0;
    for (int r = 0; r < 20; r++) run_pulse(HI_LEN, HI_LEN + LAT + 2, np, f, s);
    chk("t4 saturated", count[3:0], 15);
    signal[0] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT - 1) clear[0] = 1'b1;
    end
    clear = '0;
    chk("t4 clr+edge pulse", edge_seen[0], 1);
    chk("t4 clr+edge count", count[3:0], 1);
    chk("t4 clr+edge sticky", sticky[0], 1);
    clear[0] = 1'b1; tick(); clear = '0;
    chk("t4 clear count", count[3:0], 0);
    chk("t4 clear sticky", sticky[0], 0);

    // Reset mid-run with ch2 held high
    mode = 8'h10;
    signal = 4'b0100;
    wait_pulse(2, 40, c);
    chk("t5 pre pulse", c, LAT);
    tick();
    chk("t5 pre count", count[11:8], 1);
    reset_n = 1'b0;
    #2;
    chk("t5 async edge_seen", edge_seen, 0);
    chk("t5 async level", level, 0);
    chk("t5 async sticky", sticky, 0);
    chk("t5 async count", count, 0);
    tick(); tick();
    reset_n = 1'b1;
    wait_pulse(2, 40, c);
    chk("t5 post pulse", c, LAT);
    tick();
    chk("t5 post single", edge_seen, 0);
    chk("t5 post count", count, 16'h0100);

    // Steady-state table: mode off/on, per-channel independence
    for (int i = 0; i < 12; i++) begin
      signal = tbl[i].sig; mode = tbl[i].md; clear = tbl[i].clr;
      repeat (HOLD) tick();
      chk($sformatf("tbl%0d edge_seen", i), edge_seen, 0);
      chk($sformatf("tbl%0d level", i), level, tbl[i].lvl);
      chk($sformatf("tbl%0d sticky", i), sticky, tbl[i].stk);
      chk($sformatf("tbl%0d count", i), count, tbl[i].cnt);
    end
    clear = '0;

    // Simultaneous edges on all channels
    signal = 4'b1010;
    wait_pulse(0, 40, c);
    chk("t6 simul latency", c, LAT);
    chk("t6 simul all", edge_seen, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
